muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
Iterative sequencer for the MIPS MULT/DIV instructions. Computes a signed 32x32 multiply with a 64-bit product, or a signed 32/32 divide giving quotient and remainder, in HI/LO.
The main control unit pulses start, then stalls its FSM while busy=1. The result is written to HI/LO once, at completion.
Shift-add multiply and restoring divide run on one shared 64-bit accumulator, one bit per cycle.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH each; iteration count = WIDTH

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
start  input  1  request from control unit; sampled only in IDLE
op  input  1  0 = MULT, 1 = DIV; sampled with start
a  input  WIDTH  operand A (multiplicand / dividend), signed; sampled with start
b  input  WIDTH  operand B (multiplier / divisor), signed; sampled with start
hi  output  WIDTH  MULT: product[63:32]; DIV: remainder
lo  output  WIDTH  MULT: product[31:0]; DIV: quotient
busy  output  1  high in PREP, RUN, FIX and DONE; low in IDLE
done  output  1  one-cycle pulse; hi/lo valid from this cycle
div_zero  output  1  one-cycle pulse coincident with done when DIV had b==0

Behaviour:
- Reset (reset=0, async): state=IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0; iteration counter=0.
- Reset mid-operation aborts the operation. hi/lo return to 0 and no done is issued.
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE: on an edge with start=1, latch op, sign(a), sign(b), |a|, |b|, then go to PREP. Call this edge E0.
- PREP (E0->E1): load the accumulator and set counter=WIDTH.
  - DIV with b==0: go directly to DONE at E1 and set div_zero.
  - Otherwise go to RUN.
- RUN: one iteration per edge and the counter decrements each time. At the edge where counter reaches 0, go to FIX. Without the optional feature, RUN edges are E2..E33.
  - MULT: if the current multiplier LSB=1, add the multiplicand to the upper half. Then shift right by 1.
  - DIV: shift remainder:quotient left by 1 and trial-subtract the divisor. If the result is non-negative, keep it and set quotient LSB=1; otherwise restore.
- FIX (one edge, E34): apply sign correction and load hi/lo, then go to DONE.
  - MULT: negate the 64-bit product if sign(a)!=sign(b).
  - DIV: negate the quotient if the signs differ. The remainder takes the sign of a.
- DONE (one cycle, E34->E35): done=1, div_zero as latched; then go to IDLE.
- Latency: done is high in the cycle between E34 and E35 (fixed, 35 edges start-to-idle). DIV by zero: done is high between E1 and E2.
- hi/lo change only on the FIX->DONE edge and hold between operations. A DIV by zero leaves hi/lo unchanged.
- start while busy=1: ignored, with no queueing. Operands may change freely after E0.
- Overflow case a=0x80000000, b=0xFFFFFFFF (DIV): lo=0x80000000, hi=0 (two's-complement wrap, no flag).
- Negation and abs are modulo 2^WIDTH. |0x80000000| is treated as unsigned 0x80000000.

Optional Feature:
MULT_EARLY_EXIT_EN
- Defined: in RUN for MULT only, if the remaining multiplier bits after the current iteration's shift are all 0, go to FIX on that edge. The product must equal the full-iteration result; DIV timing is unchanged.
- Undefined: MULT always runs the full WIDTH iterations, with fixed latency.

Test Plan:
- MULT a=7, b=0xFFFFFFFD (-3) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done pulse exactly between E34 and E35; busy high E0..E35.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div_zero=0.
- DIV a=0x1234, b=0 -> done and div_zero high between E1 and E2; hi/lo keep the previous values.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; then a start pulse at E10 of a following MULT is ignored, with only one done.
- reset driven low mid-RUN (E15) of MULT 3*5 -> outputs 0 immediately, no done; after release, MULT 3*5 -> lo=15, hi=0.
- MULT_EARLY_EXIT_EN defined, MULT a=5, b=1 -> lo=5, hi=0, done between E3 and E4. Undefined -> same result, done between E34 and E35.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Handshake and result bundle between the MIPS control unit and the MULT/DIV sequencer.
// master = control unit (drives requests), slave = sequencer (drives HI/LO and status).
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (output start, op, a, b, input hi, lo, busy, done, div_zero);
  modport slave  (input start, op, a, b, output hi, lo, busy, done, div_zero);
endinterface

// File: rtl/muldiv_seq.sv
// Iterative signed MULT/DIV sequencer: shift-add multiply and restoring divide on one shared accumulator.
// Optional macro MULT_EARLY_EXIT_EN: MULT leaves RUN once the remaining multiplier bits are all zero.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]         state;
  logic               op_r;
  logic               sign_a;
  logic               sign_b;
  logic               dz_r;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      cnt;

  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   diff;
  logic               ge;
  logic               early_exit;
  logic [2*WIDTH-1:0] prod_aligned;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quo_signed;
  logic [WIDTH-1:0]   rmd_signed;

  // One iteration: MULT adds the multiplicand into the upper half (carry kept) then shifts right;
  // DIV shifts left and keeps the trial difference only when the divisor fits.
  always_comb begin
    msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, abs_a};
    rem      = acc[2*WIDTH-1:WIDTH-1];
    ge       = (rem >= {1'b0, abs_b});
    diff     = rem[WIDTH-1:0] - abs_b;
    acc_next = acc;
    if (!op_r) begin
      acc_next = acc[0] ? {msum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    end else begin
      acc_next = ge ? {diff, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
    end
  end

`ifdef MULT_EARLY_EXIT_EN
  localparam logic [2*WIDTH-1:0] ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};
  logic [CW-1:0]      cnt_next;
  logic [2*WIDTH-1:0] rem_mask;

  // The low cnt_next bits of the shifted accumulator are the multiplier bits still to be consumed;
  // skipped iterations would only shift right, so FIX realigns by the leftover count.
  always_comb begin
    cnt_next     = cnt - CW'(1);
    rem_mask     = (ONE << cnt_next) - ONE;
    early_exit   = !op_r && ((acc_next & rem_mask) == '0);
    prod_aligned = acc >> cnt;
  end
`else
  always_comb begin
    early_exit   = 1'b0;
    prod_aligned = acc;
  end
`endif

  always_comb begin
    prod_signed = (sign_a ^ sign_b) ? -prod_aligned : prod_aligned;
    quo_signed  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rmd_signed  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      op_r   <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      dz_r   <= 1'b0;
      abs_a  <= '0;
      abs_b  <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_r   <= bus.op;
            sign_a <= bus.a[WIDTH-1];
            sign_b <= bus.b[WIDTH-1];
            abs_a  <= bus.a[WIDTH-1] ? -bus.a : bus.a;
            abs_b  <= bus.b[WIDTH-1] ? -bus.b : bus.b;
            dz_r   <= 1'b0;
            state  <= S_PREP;
          end
        end
        S_PREP: begin
          cnt <= CW'(WIDTH);
          acc <= op_r ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
          if (op_r && (abs_b == '0)) begin
            dz_r  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= acc_next;
          cnt <= cnt - CW'(1);
          if ((cnt == CW'(1)) || early_exit) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          if (!op_r) begin
            hi_r <= prod_signed[2*WIDTH-1:WIDTH];
            lo_r <= prod_signed[WIDTH-1:0];
          end else begin
            hi_r <= rmd_signed;
            lo_r <= quo_signed;
          end
          cnt   <= '0;
          state <= S_DONE;
        end
        S_DONE: begin
          dz_r  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
  assign bus.div_zero = (state == S_DONE) && dz_r;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: results, done/busy timing, divide-by-zero,
// ignored start while busy and asynchronous reset abort. Honours MULT_EARLY_EXIT_EN for timing.
module tb_muldiv_seq;
  localparam int WIDTH = 32;
`ifdef MULT_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  localparam int RST_EDGE = EE ? 3 : 15;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  muldiv_seq_if #(.WIDTH(WIDTH)) bus ();
  muldiv_seq #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Launches one operation (E0 = first edge with start high) and watches 44 further edges.
  task automatic applyStimulus(input logic op_in, input logic [31:0] a_in, input logic [31:0] b_in,
                               input int extra_edge,
                               output int done_edge, output int done_cnt, output int dz_cnt,
                               output int dz_at_done, output logic [31:0] hi_seen,
                               output logic [31:0] lo_seen, output int busy0,
                               output int idle_edge, output int busy_again);
    done_edge = -1; done_cnt = 0; dz_cnt = 0; dz_at_done = -1;
    hi_seen = '0; lo_seen = '0; idle_edge = -1; busy_again = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op_in; bus.a = a_in; bus.b = b_in;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.a = 32'hDEADBEEF; bus.b = 32'h0;
    busy0 = int'(bus.busy);
    for (int n = 1; n <= 44; n++) begin
      @(negedge clk);
      bus.start = (n == extra_edge);
      @(posedge clk);
      #1;
      if (bus.div_zero) dz_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_edge < 0) begin
          done_edge  = n;
          dz_at_done = int'(bus.div_zero);
          hi_seen    = bus.hi;
          lo_seen    = bus.lo;
        end
      end
      if (idle_edge >= 0 && bus.busy) busy_again = 1;
      if (idle_edge < 0 && !bus.busy) idle_edge = n;
    end
    bus.start = 1'b0;
  endtask

  task automatic runCase(input string tag, input logic op_in, input logic [31:0] a_in,
                         input logic [31:0] b_in, input int extra_edge,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int exp_dz, input int exp_edge);
    int done_edge, done_cnt, dz_cnt, dz_at_done, busy0, idle_edge, busy_again;
    logic [31:0] hi_seen, lo_seen;
    applyStimulus(op_in, a_in, b_in, extra_edge, done_edge, done_cnt, dz_cnt, dz_at_done,
                  hi_seen, lo_seen, busy0, idle_edge, busy_again);
    checkOutput({tag, ".hi"}, 64'(hi_seen), 64'(exp_hi));
    checkOutput({tag, ".lo"}, 64'(lo_seen), 64'(exp_lo));
    checkOutput({tag, ".dz_at_done"}, 64'(dz_at_done), 64'(exp_dz));
    checkOutput({tag, ".dz_count"}, 64'(dz_cnt), 64'(exp_dz));
    checkOutput({tag, ".done_edge"}, 64'(done_edge), 64'(exp_edge));
    checkOutput({tag, ".done_count"}, 64'(done_cnt), 64'd1);
    checkOutput({tag, ".busy_e0"}, 64'(busy0), 64'd1);
    checkOutput({tag, ".idle_edge"}, 64'(idle_edge), 64'(exp_edge + 1));
    checkOutput({tag, ".busy_again"}, 64'(busy_again), 64'd0);
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, ".hi"}, 64'(bus.hi), 64'd0);
    checkOutput({tag, ".lo"}, 64'(bus.lo), 64'd0);
    checkOutput({tag, ".busy"}, 64'(bus.busy), 64'd0);
    checkOutput({tag, ".done"}, 64'(bus.done), 64'd0);
    checkOutput({tag, ".div_zero"}, 64'(bus.div_zero), 64'd0);
  endtask

  initial begin
    int saw_done;
    reset = 1'b0;
    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    #1;
    checkIdleZero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    runCase("mult_7_m3",   1'b0, 32'd7,        32'hFFFFFFFD, -1, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, EE ? 4 : 34);
    runCase("div_m7_2",    1'b1, 32'hFFFFFFF9, 32'd2,        -1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 34);
    runCase("div_by_zero", 1'b1, 32'h1234,     32'd0,        -1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1, 1);
    runCase("div_ovf",     1'b1, 32'h80000000, 32'hFFFFFFFF, -1, 32'h00000000, 32'h80000000, 0, 34);
    runCase("mult_ignore", 1'b0, 32'h00010000, 32'h00010000, 10, 32'h00000001, 32'h00000000, 0, EE ? 19 : 34);
    runCase("mult_min_sq", 1'b0, 32'h80000000, 32'h80000000, -1, 32'h40000000, 32'h00000000, 0, 34);
    runCase("mult_m1_m1",  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 32'h00000000, 32'h00000001, 0, EE ? 3 : 34);
    runCase("mult_max_sq", 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, -1, 32'h3FFFFFFF, 32'h00000001, 0, EE ? 33 : 34);
    runCase("div_100_m7",  1'b1, 32'd100,      32'hFFFFFFF9, -1, 32'h00000002, 32'hFFFFFFF2, 0, 34);
    runCase("div_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, -1, 32'hFFFFFFFE, 32'h0000000E, 0, 34);
    runCase("div_5_10",    1'b1, 32'd5,        32'd10,       -1, 32'h00000005, 32'h00000000, 0, 34);

    // Abort a MULT mid-RUN with an asynchronous reset between clock edges.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'd3; bus.b = 32'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int n = 1; n <= RST_EDGE; n++) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkIdleZero("reset_abort");
    saw_done = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) saw_done = 1;
    end
    checkOutput("reset_abort.no_done", 64'(saw_done), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    runCase("mult_3_5",    1'b0, 32'd3,        32'd5,        -1, 32'h00000000, 32'h0000000F, 0, EE ? 5 : 34);
    runCase("mult_5_1",    1'b0, 32'd5,        32'd1,        -1, 32'h00000000, 32'h00000005, 0, EE ? 3 : 34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
